ps2_host_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (for example `0xED` set-LEDs, or `0xFF` reset) to the keyboard over the same bidirectional clock/data pair that `KEY_CONTROLLER` receives from. It sits beside `KEY_CONTROLLER` in `Battleship` and drives the pads through open-drain enables. The top level ties each pad low when its enable is 1 and to `z` otherwise. While `tx_busy` is high, the receiver must ignore the bus.

---
 rtl/ps2_host_transmitter.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then clocks
// out one command byte on device-generated falling edges and checks the ack.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 3240,
    parameter int unsigned REQ_CYCLES     = 27,
    parameter int unsigned START_TIMEOUT  = 405000,
    parameter int unsigned PACKET_TIMEOUT = 54000
) (
    input  logic       clock27,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       keyboardClock_in,
    input  logic       keyboardData_in,
    output logic       keyboardClock_oe,
    output logic       keyboardData_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_DATA, S_RELEASE, S_DONE, S_ERROR
    } state_e;

    localparam logic [18:0] INHIBIT_LAST  = 19'(INHIBIT_CYCLES - 1);
    localparam logic [18:0] REQ_LAST      = 19'(REQ_CYCLES - 1);
    localparam logic [18:0] START_LIMIT   = 19'(START_TIMEOUT);
    localparam logic [18:0] PACKET_LIMIT  = 19'(PACKET_TIMEOUT);

    state_e      state_q, state_d;
    logic [18:0] timer_q, timer_d, timer_inc;
    logic [3:0]  count_q, count_d;
    logic [9:0]  shift_q, shift_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_prev_q;
    logic        fall;

    // NOTE: pads idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], keyboardClock_in};
            data_sync_q <= {data_sync_q[0], keyboardData_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall      = clk_prev_q & ~clk_sync_q[1];
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 19'd1;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        count_d   = count_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_start) begin
                    state_d  = S_INHIBIT;
                    shift_d  = {1'b1, ~^tx_data, tx_data};
                    count_d  = '0;
                    clk_oe_d = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    state_d   = S_REQ;
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                end
            end
            S_REQ: begin
                if (timer_q == REQ_LAST) begin
                    state_d  = S_WAIT_CLK;
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                end
            end
            S_WAIT_CLK: begin
                if (timer_q >= START_LIMIT) begin
                    state_d   = S_ERROR;
                    data_oe_d = 1'b0;
                end else if (fall) begin
                    state_d   = S_DATA;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    count_d   = 4'd1;
                    timer_d   = '0;
                end
            end
            S_DATA: begin
                if (timer_q >= PACKET_LIMIT) begin
                    state_d   = S_ERROR;
                    data_oe_d = 1'b0;
                end else if (fall) begin
                    if (count_q == 4'd10) begin
                        // Fall 11: the device pulls data low to acknowledge.
                        state_d   = data_sync_q[1] ? S_ERROR : S_RELEASE;
                        timer_d   = '0;
                        data_oe_d = 1'b0;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        count_d   = count_q + 4'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (timer_q >= PACKET_LIMIT) begin
                    state_d = S_ERROR;
                end else if (clk_sync_q[1] && data_sync_q[1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERROR: begin
                state_d   = S_IDLE;
                timer_d   = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign tx_done          = (state_q == S_DONE);
    assign tx_error         = (state_q == S_ERROR);
    assign keyboardClock_oe = clk_oe_q;
    assign keyboardData_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench: an open-drain bus model plus a keyboard BFM that clocks the
// frame, samples on rising edges and optionally acks. Timing parameters are scaled down.
module tb_ps2_host_transmitter;

    localparam int INH  = 20;
    localparam int REQ  = 5;
    localparam int ST   = 300;
    localparam int PT   = 2000;
    localparam int HALF = 20;

    logic       clock27 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       keyboardClock_oe, keyboardData_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbd_clk, kbd_data;

    assign kbd_clk  = !(keyboardClock_oe || dev_clk_low);
    assign kbd_data = !(keyboardData_oe || dev_data_low);

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .START_TIMEOUT(ST), .PACKET_TIMEOUT(PT)
    ) dut (
        .clock27(clock27), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .keyboardClock_in(kbd_clk), .keyboardData_in(kbd_data),
        .keyboardClock_oe(keyboardClock_oe), .keyboardData_oe(keyboardData_oe)
    );

    always #5 clock27 = ~clock27;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor, sampled on the falling clock edge.
    int   done_cnt = 0, err_cnt = 0, end_ok = 0, overlap = 0;
    int   run = 0, last_run = 0, since_rise = 0, data_off = -1, since_fall = 0, err_delay = -1;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_busy = 1'b0;

    always @(negedge clock27) begin
        prev_clk_oe  <= keyboardClock_oe;
        prev_data_oe <= keyboardData_oe;
        prev_busy    <= tx_busy;
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
        if ((tx_done || tx_error) && !tx_busy && prev_busy) end_ok <= end_ok + 1;
        if (tx_done && tx_error) overlap <= overlap + 1;
        if (keyboardClock_oe) run <= run + 1;
        else begin
            if (prev_clk_oe) last_run <= run;
            run <= 0;
        end
        since_rise <= (keyboardClock_oe && !prev_clk_oe) ? 0 : since_rise + 1;
        if (keyboardData_oe && !prev_data_oe && keyboardClock_oe) data_off <= since_rise + 1;
        since_fall <= (!keyboardClock_oe && prev_clk_oe) ? 0 : since_fall + 1;
        if (tx_error) err_delay <= since_fall + 1;
    end

    task automatic start_tx(input string tag, input logic [7:0] b);
        @(negedge clock27);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clock27);
        tx_start = 1'b0;
        check({tag, "_clk_oe_latency"}, keyboardClock_oe, 1);
        check({tag, "_busy_after_start"}, tx_busy, 1);
    endtask

    task automatic wait_release(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < INH + REQ + 50; i++) begin
            @(negedge clock27);
            if (!keyboardClock_oe && keyboardData_oe) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_clock_released"}, got, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < PT + 100; i++) begin
            @(negedge clock27);
            if (!tx_busy) begin
                got = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clock27);
        check({tag, "_idle_reached"}, got, 1);
    endtask

    // Keyboard side: frame[0] is the start bit seen before clocking, frame[1..10]
    // are the values sampled on rising edges 1..10. Returns early (clock held low)
    // after fall abort_after when it is nonzero.
    task automatic device_frame(input bit ack, input int abort_after, input bit poke,
                                output logic [10:0] frame);
        frame = '0;
        repeat (10) @(negedge clock27);
        frame[0] = kbd_data;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock27);
            if (i == abort_after) return;
            dev_clk_low = 1'b0;
            frame[i] = kbd_data;
            if (poke && i == 4) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clock27);
                tx_start = 1'b0;
                repeat (HALF - 1) @(negedge clock27);
            end else begin
                repeat (HALF) @(negedge clock27);
            end
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clock27);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock27);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clock27);
        dev_data_low = 1'b0;
    endtask

    task automatic run_transfer(input string tag, input logic [7:0] b, input logic [10:0] exp_frame,
                                input bit ack, input bit poke);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int k0 = end_ok;
        logic [10:0] fr;
        start_tx(tag, b);
        wait_release(tag);
        device_frame(ack, 0, poke, fr);
        wait_idle(tag);
        check({tag, "_frame"}, fr, exp_frame);
        check({tag, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, "_error_pulses"}, err_cnt - e0, ack ? 0 : 1);
        check({tag, "_busy_falls_with_pulse"}, end_ok - k0, 1);
        check({tag, "_clk_oe_width"}, last_run, INH + REQ);
        check({tag, "_data_oe_offset"}, data_off, INH);
        check({tag, "_enables_released"}, {keyboardClock_oe, keyboardData_oe}, 2'b00);
    endtask

    initial begin
        logic [10:0] fr;
        int e0, d0;
        bit got;

        repeat (3) @(negedge clock27);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_error", tx_error, 0);
        check("reset_enables", {keyboardClock_oe, keyboardData_oe}, 2'b00);
        reset_n = 1'b1;
        repeat (3) @(negedge clock27);
        check("idle_enables", {keyboardClock_oe, keyboardData_oe}, 2'b00);

        // Frames are {stop, parity, d7..d0, start}.
        run_transfer("xfer_ED", 8'hED, 11'b1_1_1110_1101_0, 1'b1, 1'b0);
        run_transfer("xfer_02", 8'h02, 11'b1_0_0000_0010_0, 1'b1, 1'b0);
        run_transfer("no_ack",  8'hED, 11'b1_1_1110_1101_0, 1'b0, 1'b0);
        run_transfer("poke_FF", 8'hFF, 11'b1_1_1111_1111_0, 1'b1, 1'b1);

        // Start timeout: the device never clocks.
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx("start_to", 8'h55);
        wait_release("start_to");
        got = 1'b0;
        for (int i = 0; i < ST + 100; i++) begin
            @(negedge clock27);
            if (err_cnt != e0) begin
                got = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clock27);
        check("start_to_seen", got, 1);
        check("start_to_delay", err_delay, ST + 1);
        check("start_to_err_pulses", err_cnt - e0, 1);
        check("start_to_no_done", done_cnt - d0, 0);
        check("start_to_enables", {keyboardClock_oe, keyboardData_oe}, 2'b00);

        // Reset while the device holds clock low after fall 5 (bit 4 of 0xAA is 0).
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx("mid_rst", 8'hAA);
        wait_release("mid_rst");
        device_frame(1'b1, 5, 1'b0, fr);
        check("mid_rst_pre_data_oe", keyboardData_oe, 1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_enables", {keyboardClock_oe, keyboardData_oe}, 2'b00);
        check("mid_rst_outputs", {tx_busy, tx_done, tx_error}, 3'b000);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clock27);
        reset_n = 1'b1;
        repeat (20) @(negedge clock27);
        check("mid_rst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        run_transfer("after_rst_F4", 8'hF4, 11'b1_0_1111_0100_0, 1'b1, 1'b0);

        check("no_done_error_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
